// File: rtl/riscv_types.sv
// riscv_types: shared scheduler types and defaults
//   STARVE_DEFAULT : head-wait cycles before forcing a drain
//   sched_state_t  : writeback scheduler FSM states
//   wb_result_t    : long-unit result record (destination index + data)
package riscv_types;
    localparam int STARVE_DEFAULT = 8;
    localparam int XLEN = 32;
    localparam int REG_IDX = 5;
    typedef enum logic {NORMAL, DRAIN} sched_state_t;
    typedef struct packed {
        logic [REG_IDX-1:0] rd;
        logic [XLEN-1:0]    data;
    } wb_result_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry buffer of long-unit results awaiting the RF write port
//   clk_in, rst_in       : clock, async active-high reset (discards contents)
//   push, push_rd/data   : enqueue a result
//   pop                  : dequeue the head
//   head_rd, head_data   : current head entry
//   empty, full, last    : occupancy flags (last = exactly one entry)
module wb_fifo #(
    parameter int WIDTH = 32,
    parameter int INDEX = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic [INDEX-1:0] push_rd,
    input  logic [WIDTH-1:0] push_data,
    output logic [INDEX-1:0] head_rd,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic             last
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [INDEX+WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign {head_rd, head_data} = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);
    assign last  = count == CW'(1);
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= {push_rd, push_data};
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: arbitrates the RF write port between pipeline WB and long-unit results
//   clk_in, rst_in                    : clock, async active-high reset
//   id_valid_in, rs1/rs2, uses_rs1/2  : ID stage source operands
//   rd_in, writes_rd_in, issue_long_in: ID stage destination / long-op issue
//   stall_out                         : ID stall (RAW, WAW or forced drain)
//   wb_we_in, wb_rd_in, wb_data_in    : pipeline writeback, always wins the port
//   lu_valid_in, lu_rd_in, lu_data_in, lu_ready_out : long-unit result handshake
//   we_out, rd_out, data_out          : RF write port
module rf_wb_scheduler
    import riscv_types::*;
#(
    parameter int WIDTH  = 32,
    parameter int INDEX  = 5,
    parameter int DEPTH  = 2,
    parameter int STARVE = STARVE_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             id_valid_in,
    input  logic [INDEX-1:0] rs1_in,
    input  logic [INDEX-1:0] rs2_in,
    input  logic             uses_rs1_in,
    input  logic             uses_rs2_in,
    input  logic [INDEX-1:0] rd_in,
    input  logic             writes_rd_in,
    input  logic             issue_long_in,
    output logic             stall_out,
    input  logic             wb_we_in,
    input  logic [INDEX-1:0] wb_rd_in,
    input  logic [WIDTH-1:0] wb_data_in,
    input  logic             lu_valid_in,
    input  logic [INDEX-1:0] lu_rd_in,
    input  logic [WIDTH-1:0] lu_data_in,
    output logic             lu_ready_out,
    output logic             we_out,
    output logic [INDEX-1:0] rd_out,
    output logic [WIDTH-1:0] data_out
);
    localparam int CW = $clog2(STARVE + 1);
    localparam int NR = 2 ** INDEX;
    sched_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [NR-1:0] pending, pending_n;
    logic [INDEX-1:0] head_rd, clr_rd;
    logic [WIDTH-1:0] head_data;
    logic empty, full, last;
    logic wb_act, lu_acc, pop, push, bypass, lu_wr, issue, hazard;
    assign wb_act       = wb_we_in && wb_rd_in != '0;
    assign lu_ready_out = !rst_in && !full;
    assign lu_acc       = lu_valid_in && lu_ready_out;
    assign pop          = !rst_in && !empty && !wb_act;
    assign bypass       = empty && !wb_act && lu_acc;
    assign push         = lu_acc && !bypass;
    assign lu_wr        = pop || bypass;
    assign clr_rd       = pop ? head_rd : lu_rd_in;
    assign we_out       = !rst_in && (wb_act || lu_wr);
    assign rd_out       = rst_in ? '0 : wb_act ? wb_rd_in : pop ? head_rd : bypass ? lu_rd_in : '0;
    assign data_out     = rst_in ? '0 : wb_act ? wb_data_in : pop ? head_data : bypass ? lu_data_in : '0;
    assign hazard       = (uses_rs1_in && pending[rs1_in]) || (uses_rs2_in && pending[rs2_in])
                        || (writes_rd_in && pending[rd_in]);
    assign stall_out    = !rst_in && ((id_valid_in && hazard) || state == DRAIN);
    assign issue        = id_valid_in && issue_long_in && writes_rd_in && !stall_out && rd_in != '0;
    assign cnt_inc      = (empty || pop) ? '0 : cnt + 1'b1;
    wb_fifo #(.WIDTH(WIDTH), .INDEX(INDEX), .DEPTH(DEPTH)) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push),
        .pop       (pop),
        .push_rd   (lu_rd_in),
        .push_data (lu_data_in),
        .head_rd   (head_rd),
        .head_data (head_data),
        .empty     (empty),
        .full      (full),
        .last      (last)
    );
    // A new issue is applied after the clear so it wins if both hit one index.
    always_comb begin
        pending_n = pending;
        if (lu_wr) pending_n[clr_rd] = 1'b0;
        if (issue) pending_n[rd_in] = 1'b1;
        pending_n[0] = 1'b0;
    end
    // DRAIN exits on the edge where the FIFO's last entry leaves without a refill.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == NORMAL) begin
            cnt_n   = cnt_inc;
            state_n = cnt_inc == CW'(STARVE) ? DRAIN : NORMAL;
        end else if (empty || (pop && !push && last)) begin
            state_n = NORMAL;
            cnt_n   = '0;
        end
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= NORMAL;
            cnt     <= '0;
            pending <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pending_n;
        end
    end
endmodule
